// File: rtl/nibble_serial_add_seq_if.sv
// Operand/result bundle for the nibble-serial adder: start/busy/done handshake
// plus the wide operands and results.
interface nibble_serial_add_seq_if #(
    parameter int NIBBLES = 4
);
    localparam int W = 4 * NIBBLES;

    logic         start;
    logic         op_sub;
    logic         cin;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         busy;
    logic         done;
    logic [W-1:0] sum;
    logic         cout;
    logic         ovf;

    modport master (
        output start, op_sub, cin, a, b,
        input  busy, done, sum, cout, ovf
    );

    modport slave (
        input  start, op_sub, cin, a, b,
        output busy, done, sum, cout, ovf
    );
endinterface

// File: rtl/nibble_serial_add_seq.sv
// Wide add/subtract computed one nibble per clock (LSB first) through a single
// 4-bit ripple-carry slice, with the inter-nibble carry held in a register.
module nibble_serial_add_seq #(
    parameter int NIBBLES = 4
) (
    input  logic                   clk,
    input  logic                   rst_n,
    nibble_serial_add_seq_if.slave bus
);
    localparam int W  = 4 * NIBBLES;
    localparam int IW = $clog2(NIBBLES);
    localparam logic [IW-1:0] LAST_IDX = IW'(NIBBLES - 1);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t                     state_reg, state_next;
    logic [IW-1:0]              idx_reg;
    logic                       carry_reg;
    logic [NIBBLES-1:0][3:0]    a_reg;
    logic [NIBBLES-1:0][3:0]    b_reg;
    logic [NIBBLES-1:0][3:0]    sum_reg;
    logic                       cout_reg;
    logic                       ovf_reg;

    logic                       accept;
    logic                       last_nibble;

    logic [3:0]                 slice_a;
    logic [3:0]                 slice_b;
    logic [3:0]                 slice_s;
    logic [4:0]                 slice_c;

    // Shared 4-bit ripple-carry slice; slice_c[3] is the carry into the MSB.
    assign slice_a    = a_reg[idx_reg];
    assign slice_b    = b_reg[idx_reg];
    assign slice_c[0] = carry_reg;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_fa
            assign slice_s[gi]   = slice_a[gi] ^ slice_b[gi] ^ slice_c[gi];
            assign slice_c[gi+1] = (slice_a[gi] & slice_b[gi]) |
                                   (slice_c[gi] & (slice_a[gi] ^ slice_b[gi]));
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next  = state_reg;
        accept      = 1'b0;
        last_nibble = 1'b0;
        case (state_reg)
            IDLE, DONE: begin
                if (bus.start) begin
                    accept     = 1'b1;
                    state_next = RUN;
                end else begin
                    state_next = IDLE;
                end
            end
            RUN: begin
                if (idx_reg == LAST_IDX) begin
                    last_nibble = 1'b1;
                    state_next  = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Subtraction is a + ~b + 1: invert B on capture and preload the carry.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            idx_reg   <= '0;
            carry_reg <= 1'b0;
            a_reg     <= '0;
            b_reg     <= '0;
            sum_reg   <= '0;
            cout_reg  <= 1'b0;
            ovf_reg   <= 1'b0;
        end else if (accept) begin
            a_reg     <= bus.a;
            b_reg     <= bus.op_sub ? ~bus.b : bus.b;
            carry_reg <= bus.op_sub ? 1'b1 : bus.cin;
            idx_reg   <= '0;
        end else if (state_reg == RUN) begin
            sum_reg[idx_reg] <= slice_s;
            carry_reg        <= slice_c[4];
            if (last_nibble) begin
                cout_reg <= slice_c[4];
                ovf_reg  <= slice_c[3] ^ slice_c[4];
            end else begin
                idx_reg <= idx_reg + IW'(1);
            end
        end
    end

    assign bus.busy = (state_reg == RUN);
    assign bus.done = (state_reg == DONE);
    assign bus.sum  = sum_reg;
    assign bus.cout = cout_reg;
    assign bus.ovf  = ovf_reg;
endmodule
